pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, PC value loaded by reset.
REQ-003 SHALL have parameter CNT_W, default 16, redirect-counter width in bits.
REQ-004 SHALL have ports (clock and reset first):
- i_clk  in  1  sole clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_pc  out  XLEN  current fetch PC.
- o_pc_valid  out  1  o_pc is offered to the IFU.
- i_pc_ready  in  1  IFU accepts o_pc.
- i_cmt_valid  in  1  EXU/LSU commit of the instruction at o_pc.
- i_brch, i_zero, i_jal, i_jalr, i_ecall, i_mret  in  1 each  control outcome of the committed instruction.
- i_rs1, i_imm, i_mtvec, i_mepc  in  XLEN each  operands and trap vectors.
- o_redir_cnt  out  CNT_W  count of committed non-sequential PC updates.
- o_misalign  out  1  one-cycle pulse: misaligned target trapped (macro-gated).
- o_badaddr  out  XLEN  offending target (macro-gated).

Function
REQ-005 SHALL implement a two-state FSM: S_FETCH (o_pc_valid=1) and S_EXEC (o_pc_valid=0).
REQ-006 SHALL move S_FETCH -> S_EXEC on the cycle o_pc_valid && i_pc_ready; o_pc SHALL be held stable while o_pc_valid=1 and i_pc_ready=0.
REQ-007 SHALL, in S_EXEC, wait any number of cycles for i_cmt_valid; on i_cmt_valid load next PC into o_pc and return to S_FETCH the following cycle.
REQ-008 SHALL ignore i_cmt_valid and all outcome inputs while in S_FETCH.
REQ-009 SHALL select next PC with fixed priority: i_ecall -> i_mtvec; else i_mret -> i_mepc; else (i_brch && !i_zero) || i_jal -> o_pc + i_imm; else i_jalr -> (i_rs1 + i_imm) with bit 0 cleared; else o_pc + 4.
REQ-010 SHALL compute all additions modulo 2^XLEN (carry discarded; wrap from all-ones to low addresses is legal).
REQ-011 SHALL resolve simultaneous i_ecall and i_mret to i_ecall, and simultaneous taken branch/jal and jalr to o_pc + i_imm.
REQ-012 SHALL increment o_redir_cnt by 1 on each commit whose next PC is not o_pc + 4 by selection (trap, mret, taken branch, jal, jalr, misalign trap), saturating at all-ones (no wrap).
REQ-013 SHALL produce the first o_pc_valid=1 on the first cycle after i_rst deasserts, with o_pc = RESET_PC.

Reset
REQ-014 SHALL, while i_rst=1 at a clock edge, set o_pc=RESET_PC, FSM=S_FETCH, o_redir_cnt=0, o_misalign=0, o_badaddr=0.
REQ-015 SHALL drive o_pc_valid=0 during any cycle i_rst=1.
REQ-016 SHALL let reset abort an in-flight S_EXEC; a coincident i_cmt_valid SHALL be discarded.

Configuration
REQ-017 SHALL gate target-alignment checking with macro PC_GEN_MISALIGN_CHK_EN.
REQ-018 SHALL, when PC_GEN_MISALIGN_CHK_EN is defined, redirect to i_mtvec any taken branch/jal/jalr target with bits[1:0] != 0 (after jalr bit-0 clear), pulse o_misalign=1 for exactly the cycle after the commit, and latch the target in o_badaddr until the next misalign trap or reset; ecall/mret targets are not checked.
REQ-019 SHALL, when PC_GEN_MISALIGN_CHK_EN is undefined, take misaligned targets unchanged and tie o_misalign=0, o_badaddr=0.

Verification
REQ-020 Reset release -> o_pc=32'h8000_0000, o_pc_valid=1 next cycle; i_pc_ready held 0 for 5 cycles -> o_pc stable, o_pc_valid stays 1.
REQ-021 Fetch accept, then i_cmt_valid with no control -> o_pc=32'h8000_0004 one cycle later, o_redir_cnt unchanged.
REQ-022 o_pc=32'h8000_0010, i_brch=1, i_zero=0, i_imm=32'hFFFF_FFF0 -> o_pc=32'h8000_0000, o_redir_cnt+1; same with i_zero=1 -> 32'h8000_0014.
REQ-023 i_ecall=1 and i_mret=1 together, i_mtvec=32'h8000_0100, i_mepc=32'h8000_0200 -> o_pc=32'h8000_0100; i_jalr with i_rs1=32'h8000_0003, i_imm=0 -> 32'h8000_0002 (macro off) or i_mtvec, o_misalign pulse, o_badaddr=32'h8000_0002 (macro on).
REQ-024 CNT_W=2: four consecutive jal commits -> o_redir_cnt 1,2,3,3 (saturates).
REQ-025 i_rst=1 asserted in S_EXEC coincident with i_cmt_valid and i_jal -> o_pc=RESET_PC, o_redir_cnt=0, jump discarded.

Source files
------------

// File: rtl/pc_gen.sv
// PC generator: two-state fetch/execute sequencer that computes the next fetch PC on commit.
// Optional target-alignment trap is enabled by defining PC_GEN_MISALIGN_CHK_EN.
module pc_gen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [XLEN-1:0]  o_pc,
  output logic             o_pc_valid,
  input  logic             i_pc_ready,
  input  logic             i_cmt_valid,
  input  logic             i_brch,
  input  logic             i_zero,
  input  logic             i_jal,
  input  logic             i_jalr,
  input  logic             i_ecall,
  input  logic             i_mret,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_mtvec,
  input  logic [XLEN-1:0]  i_mepc,
  output logic [CNT_W-1:0] o_redir_cnt,
  output logic             o_misalign,
  output logic [XLEN-1:0]  o_badaddr
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

`ifdef PC_GEN_MISALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  state_t           state;
  state_t           next_state;
  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] redir_cnt;

  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  rel_target;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  jalr_target;
  logic             taken;
  logic [XLEN-1:0]  target_pc;
  logic             redirect;
  logic             check_align;
  logic             misalign_hit;
  logic [XLEN-1:0]  next_pc;
  logic             commit;

  assign commit = (state == S_EXEC) && i_cmt_valid;

  // Candidate targets; every adder wraps modulo 2^XLEN by construction.
  always_comb begin
    seq_pc      = pc + PC_STEP;
    rel_target  = pc + i_imm;
    jalr_sum    = i_rs1 + i_imm;
    jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
    taken       = (i_brch && !i_zero) || i_jal;
  end

  // Fixed-priority target selection; only branch/jal/jalr targets are alignment-checked.
  always_comb begin
    target_pc   = seq_pc;
    redirect    = 1'b0;
    check_align = 1'b0;
    if (i_ecall) begin
      target_pc = i_mtvec;
      redirect  = 1'b1;
    end else if (i_mret) begin
      target_pc = i_mepc;
      redirect  = 1'b1;
    end else if (taken) begin
      target_pc   = rel_target;
      redirect    = 1'b1;
      check_align = 1'b1;
    end else if (i_jalr) begin
      target_pc   = jalr_target;
      redirect    = 1'b1;
      check_align = 1'b1;
    end
  end

  always_comb begin
    misalign_hit = ALIGN_CHK && check_align && (target_pc[1:0] != 2'b00);
    next_pc      = misalign_hit ? i_mtvec : target_pc;
  end

  always_comb begin
    next_state = state;
    o_pc_valid = 1'b0;
    case (state)
      S_FETCH: begin
        o_pc_valid = !i_rst;
        if (i_pc_ready) next_state = S_EXEC;
      end
      S_EXEC: begin
        if (i_cmt_valid) next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Reset wins over a coincident commit, so an in-flight jump is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      redir_cnt <= '0;
    end else begin
      state <= next_state;
      if (commit) begin
        pc <= next_pc;
        if (redirect && (redir_cnt != {CNT_W{1'b1}}))
          redir_cnt <= redir_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pc        = pc;
  assign o_redir_cnt = redir_cnt;

`ifdef PC_GEN_MISALIGN_CHK_EN
  logic            misalign_pulse;
  logic [XLEN-1:0] badaddr;

  // Pulse lasts one cycle because the FSM is back in S_FETCH right after a commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      misalign_pulse <= 1'b0;
      badaddr        <= '0;
    end else begin
      misalign_pulse <= commit && misalign_hit;
      if (commit && misalign_hit) badaddr <= target_pc;
    end
  end

  assign o_misalign = misalign_pulse;
  assign o_badaddr  = badaddr;
`else
  assign o_misalign = 1'b0;
  assign o_badaddr  = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: vector table of commit outcomes plus reset/stall/saturation sequences.
// A second instance with CNT_W=2 shares all stimulus to exercise counter saturation.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] MT     = 32'h8000_0100;
  localparam logic [31:0] ME     = 32'h8000_0200;

`ifdef PC_GEN_MISALIGN_CHK_EN
  localparam logic [31:0] V13_PC  = 32'h8000_0100;
  localparam logic        V13_MIS = 1'b1;
  localparam logic [31:0] V13_BAD = 32'h8000_0002;
`else
  localparam logic [31:0] V13_PC  = 32'h8000_0002;
  localparam logic        V13_MIS = 1'b0;
  localparam logic [31:0] V13_BAD = 32'h0000_0000;
`endif

  typedef struct {
    logic        brch, zero, jal, jalr, ecall, mret;
    logic [31:0] rs1, imm, mtvec, mepc, exp_pc;
    logic        redir, exp_mis;
    logic [31:0] exp_bad;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_ready, cmt_valid;
  logic        brch, zero, jal, jalr, ecall, mret;
  logic [31:0] rs1, imm, mtvec, mepc;
  logic [31:0] pc, pc_s, badaddr, badaddr_s;
  logic        pc_valid, pc_valid_s, misalign, misalign_s;
  logic [15:0] redir_cnt;
  logic [1:0]  redir_cnt_s;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_cnt      = 0;
  vec_t vecs [14];
  vec_t v;

  always #5 clk = ~clk;

  pc_gen dut (
    .i_clk(clk), .i_rst(rst), .o_pc(pc), .o_pc_valid(pc_valid), .i_pc_ready(pc_ready),
    .i_cmt_valid(cmt_valid), .i_brch(brch), .i_zero(zero), .i_jal(jal), .i_jalr(jalr),
    .i_ecall(ecall), .i_mret(mret), .i_rs1(rs1), .i_imm(imm), .i_mtvec(mtvec), .i_mepc(mepc),
    .o_redir_cnt(redir_cnt), .o_misalign(misalign), .o_badaddr(badaddr)
  );

  pc_gen #(.CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .o_pc(pc_s), .o_pc_valid(pc_valid_s), .i_pc_ready(pc_ready),
    .i_cmt_valid(cmt_valid), .i_brch(brch), .i_zero(zero), .i_jal(jal), .i_jalr(jalr),
    .i_ecall(ecall), .i_mret(mret), .i_rs1(rs1), .i_imm(imm), .i_mtvec(mtvec), .i_mepc(mepc),
    .o_redir_cnt(redir_cnt_s), .o_misalign(misalign_s), .o_badaddr(badaddr_s)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_counts(input string tag);
    check_output({tag, " redir_cnt"}, 32'(redir_cnt), 32'(exp_cnt));
    check_output({tag, " redir_cnt_sat"}, 32'(redir_cnt_s), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
  endtask

  task automatic clear_inputs();
    cmt_valid = 1'b0; brch = 1'b0; zero = 1'b0; jal = 1'b0; jalr = 1'b0;
    ecall = 1'b0; mret = 1'b0; rs1 = '0; imm = '0; mtvec = MT; mepc = ME;
  endtask

  // One full fetch-accept / commit round trip, checked on the cycle after commit.
  task automatic apply_stimulus(input vec_t sv, input string tag);
    check_output({tag, " fetch valid"}, 32'(pc_valid), 32'd1);
    pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    check_output({tag, " exec valid"}, 32'(pc_valid), 32'd0);
    brch = sv.brch; zero = sv.zero; jal = sv.jal; jalr = sv.jalr;
    ecall = sv.ecall; mret = sv.mret; rs1 = sv.rs1; imm = sv.imm;
    mtvec = sv.mtvec; mepc = sv.mepc; cmt_valid = 1'b1;
    @(negedge clk);
    clear_inputs();
    if (sv.redir) exp_cnt++;
    check_output({tag, " pc"}, pc, sv.exp_pc);
    check_output({tag, " pc_sat_inst"}, pc_s, sv.exp_pc);
    check_output({tag, " valid after commit"}, 32'(pc_valid), 32'd1);
    check_output({tag, " misalign"}, 32'(misalign), 32'(sv.exp_mis));
    check_output({tag, " badaddr"}, badaddr, sv.exp_bad);
    check_counts(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            brch zero jal  jalr ecal mret rs1           imm           mtvec mepc exp_pc        rd   mis      bad
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        MT, ME, 32'h8000_0004,1'b0,1'b0,   32'h0};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_000C,MT, ME, 32'h8000_0010,1'b1,1'b0,   32'h0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'hFFFF_FFF0,MT, ME, 32'h8000_0000,1'b1,1'b0,   32'h0};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0000_0010,MT, ME, 32'h8000_0010,1'b1,1'b0,   32'h0};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        32'hFFFF_FFF0,MT, ME, 32'h8000_0014,1'b0,1'b0,   32'h0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h0,        32'h0,        MT, ME, 32'h8000_0100,1'b1,1'b0,   32'h0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0,        MT, ME, 32'h8000_0200,1'b1,1'b0,   32'h0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h0000_1000,32'h0000_0020,MT, ME, 32'h8000_0220,1'b1,1'b0,   32'h0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h8000_0405,32'h0,        MT, ME, 32'h8000_0404,1'b1,1'b0,   32'h0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'hFFFF_FFF8,32'h0,        MT, ME, 32'hFFFF_FFF8,1'b1,1'b0,   32'h0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        MT, ME, 32'hFFFF_FFFC,1'b0,1'b0,   32'h0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        MT, ME, 32'h0000_0000,1'b0,1'b0,   32'h0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h8000_0000,MT, ME, 32'h8000_0000,1'b1,1'b0,   32'h0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h8000_0003,32'h0,        MT, ME, V13_PC,       1'b1,V13_MIS,V13_BAD};

    rst = 1'b1; pc_ready = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check_output("reset valid", 32'(pc_valid), 32'd0);
    check_output("reset pc", pc, RST_PC);
    check_output("reset misalign", 32'(misalign), 32'd0);
    check_output("reset badaddr", badaddr, 32'd0);
    check_counts("reset");

    rst = 1'b0;
    #1;
    check_output("first valid after reset", 32'(pc_valid), 32'd1);
    // Stall the fetch; commit/outcome inputs seen during S_FETCH must be ignored.
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin cmt_valid = 1'b1; jal = 1'b1; ecall = 1'b1; imm = 32'h40; end
      @(negedge clk);
      check_output($sformatf("stall%0d pc", i), pc, RST_PC);
      check_output($sformatf("stall%0d valid", i), 32'(pc_valid), 32'd1);
    end
    clear_inputs();
    check_counts("after stall");

    for (int i = 0; i < 14; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    @(negedge clk);
    check_output("misalign one-cycle", 32'(misalign), 32'd0);
    check_output("badaddr held", badaddr, V13_BAD);

    // Reset lands in S_EXEC together with a jal commit.
    pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    rst = 1'b1; cmt_valid = 1'b1; jal = 1'b1; imm = 32'h100;
    @(negedge clk);
    clear_inputs();
    exp_cnt = 0;
    check_output("abort pc", pc, RST_PC);
    check_output("abort valid in reset", 32'(pc_valid), 32'd0);
    check_output("abort badaddr", badaddr, 32'd0);
    check_counts("abort");
    rst = 1'b0;
    #1;
    check_output("abort valid after release", 32'(pc_valid), 32'd1);

    // Long wait in S_EXEC before the commit arrives.
    @(negedge clk);
    pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("exec wait%0d valid", i), 32'(pc_valid), 32'd0);
      check_output($sformatf("exec wait%0d pc", i), pc, RST_PC);
    end
    cmt_valid = 1'b1;
    @(negedge clk);
    clear_inputs();
    check_output("late commit pc", pc, 32'h8000_0004);
    check_counts("late commit");

    // Four jal commits: 16-bit counter reaches 4, 2-bit counter sticks at 3.
    v = vecs[1];
    v.imm = 32'h8;
    for (int i = 0; i < 4; i++) begin
      v.exp_pc = 32'h8000_000C + 32'(8 * i);
      apply_stimulus(v, $sformatf("jal_sat%0d", i));
    end
    check_output("sat final value", 32'(redir_cnt_s), 32'd3);
    check_output("wide final value", 32'(redir_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
